// File: rtl/ssg_pkg.sv
// Shared constants and types for the SSG tone scheduler: channel count, period width,
// register addresses and the slot index type.
package ssg_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned PER_W  = 12;

    localparam logic [3:0] ADDR_A_FINE   = 4'h0;
    localparam logic [3:0] ADDR_A_COARSE = 4'h1;
    localparam logic [3:0] ADDR_B_FINE   = 4'h2;
    localparam logic [3:0] ADDR_B_COARSE = 4'h3;
    localparam logic [3:0] ADDR_C_FINE   = 4'h4;
    localparam logic [3:0] ADDR_C_COARSE = 4'h5;
    localparam logic [3:0] ADDR_MIXER    = 4'h7;

    typedef logic [1:0] slot_t;

    function automatic logic [3:0] fine_addr(input int unsigned ch);
        case (ch)
            0:       return ADDR_A_FINE;
            1:       return ADDR_B_FINE;
            default: return ADDR_C_FINE;
        endcase
    endfunction

    function automatic logic [3:0] coarse_addr(input int unsigned ch);
        case (ch)
            0:       return ADDR_A_COARSE;
            1:       return ADDR_B_COARSE;
            default: return ADDR_C_COARSE;
        endcase
    endfunction

endpackage

// File: rtl/ssg_regfile.sv
// Tone period and mixer registers with combinational readback.
// Unmapped addresses drop writes and read as zero.
module ssg_regfile
    import ssg_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr,
    input  logic [3:0]                     addr,
    input  logic [7:0]                     din,
    output logic [7:0]                     dout,
    output logic [NUM_CH-1:0][PER_W-1:0]   period,
    output logic [NUM_CH-1:0]              mixer_en
);

    logic [7:0] fine_q   [NUM_CH];
    logic [3:0] coarse_q [NUM_CH];
    logic [7:0] mixer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                fine_q[i]   <= '0;
                coarse_q[i] <= '0;
            end
            mixer_q <= '0;
        end else if (wr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (addr == fine_addr(i))   fine_q[i]   <= din;
                if (addr == coarse_addr(i)) coarse_q[i] <= din[3:0];
            end
            if (addr == ADDR_MIXER) mixer_q <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr == fine_addr(i))   dout = fine_q[i];
            if (addr == coarse_addr(i)) dout = {4'h0, coarse_q[i]};
        end
        if (addr == ADDR_MIXER) dout = mixer_q;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            period[i] = {coarse_q[i], fine_q[i]};
        end
    end

    // Upper mixer bits are storage only.
    assign mixer_en = mixer_q[NUM_CH-1:0];

endmodule

// File: rtl/ssg_tone_sched.sv
// Time-multiplexed SSG tone generator: one decrementer rotates over the channels,
// servicing a single slot per PHI_S cycle.
module ssg_tone_sched #(
    parameter int unsigned NUM_CH = ssg_pkg::NUM_CH,
    parameter int unsigned PER_W  = ssg_pkg::PER_W
) (
    input  logic              PHI_S,
    input  logic              RESET,
    input  logic              WR,
    input  logic [3:0]        ADDR,
    input  logic [7:0]        DIN,
    output logic [7:0]        DOUT,
    output logic [NUM_CH-1:0] TONE,
    output logic [1:0]        SLOT
);
    import ssg_pkg::*;

    slot_t                          slot_q, slot_d;
    logic [PER_W-1:0]               cnt_q [NUM_CH];
    logic [PER_W-1:0]               cnt_d [NUM_CH];
    logic [NUM_CH-1:0]              osc_q, osc_d;
    logic [NUM_CH-1:0][PER_W-1:0]   period;
    logic [NUM_CH-1:0]              mixer_en;

    ssg_regfile u_regfile (
        .clk      (PHI_S),
        .reset    (RESET),
        .wr       (WR),
        .addr     (ADDR),
        .din      (DIN),
        .dout     (DOUT),
        .period   (period),
        .mixer_en (mixer_en)
    );

    always_comb begin
        slot_d = (slot_q == slot_t'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
        cnt_d  = cnt_q;
        osc_d  = osc_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (slot_q == slot_t'(i)) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    // Period register still holds its pre-write value in a write cycle.
                    cnt_d[i] = period[i];
                    osc_d[i] = ~osc_q[i];
                end
            end
        end
    end

    always_ff @(posedge PHI_S) begin
        if (RESET) begin
            slot_q <= '0;
            osc_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
            osc_q  <= osc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign TONE = osc_q | mixer_en;
    assign SLOT = slot_q;

endmodule

// File: tb/tb_ssg_tone_sched.sv
// Directed bench for ssg_tone_sched: register map, per-channel toggle intervals,
// slot phase, period-update timing and mid-count reset.
module tb_ssg_tone_sched;

    logic       PHI_S = 1'b0;
    logic       RESET = 1'b1;
    logic       WR    = 1'b0;
    logic [3:0] ADDR  = '0;
    logic [7:0] DIN   = '0;
    logic [7:0] DOUT;
    logic [2:0] TONE;
    logic [1:0] SLOT;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0, t1, t2, tc;
    logic [2:0] prev_tone;
    logic       exp_bit;

    ssg_tone_sched dut (
        .PHI_S (PHI_S),
        .RESET (RESET),
        .WR    (WR),
        .ADDR  (ADDR),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .TONE  (TONE),
        .SLOT  (SLOT)
    );

    always #5 PHI_S = ~PHI_S;
    always @(posedge PHI_S) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge PHI_S);
        WR   = 1'b1;
        ADDR = a;
        DIN  = d;
        @(negedge PHI_S);
        WR   = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ADDR = a;
        #1;
        check_eq(tag, DOUT, exp);
    endtask

    // Returns the cycle number of the next edge at which TONE[ch] changes.
    task automatic wait_tog(input int ch, input int max, output int at);
        logic p, np;
        p  = TONE[ch];
        np = ~p;
        at = -1;
        for (int n = 0; n < max; n++) begin
            @(posedge PHI_S);
            #1;
            if (TONE[ch] !== p) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            check_eq($sformatf("tog_timeout_ch%0d", ch), TONE[ch], np);
            at = cyc;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge PHI_S);
        #1;
        check_eq("rst_slot", SLOT, 0);
        check_eq("rst_tone", TONE, 0);
        for (int a = 0; a < 16; a++) rd_reg($sformatf("rst_dout_%0d", a), 4'(a), 8'h00);

        // Release reset and write A fine = 2 on the very first edge
        @(negedge PHI_S);
        RESET = 1'b0;
        WR = 1'b1; ADDR = 4'h0; DIN = 8'h02;
        @(negedge PHI_S);
        WR = 1'b0;
        check_eq("first_edge_tone", TONE, 3'b001);
        check_eq("first_edge_slot", SLOT, 1);

        wait_tog(0, 50, t0);
        wait_tog(0, 50, t1);
        check_eq("a_p2_int1", t1 - t0, 9);
        check_eq("a_phase_slot", SLOT, 1);
        wait_tog(0, 50, t2);
        check_eq("a_p2_int2", t2 - t1, 9);

        wait_tog(1, 20, t0);
        check_eq("b_phase_slot", SLOT, 2);
        wait_tog(1, 20, t1);
        check_eq("b_p0_int", t1 - t0, 3);

        wait_tog(2, 20, t0);
        check_eq("c_phase_slot", SLOT, 0);
        wait_tog(2, 20, t1);
        check_eq("c_p0_int", t1 - t0, 3);

        // Mixer masks A and C
        wr_reg(4'h7, 8'h05);
        rd_reg("mix_rd", 4'h7, 8'h05);
        check_eq("mix_ac_high0", TONE & 3'b101, 3'b101);
        wait_tog(1, 20, t0);
        wait_tog(1, 20, t1);
        check_eq("mix_b_int", t1 - t0, 3);
        repeat (5) @(posedge PHI_S);
        #1;
        check_eq("mix_ac_high1", TONE & 3'b101, 3'b101);
        wr_reg(4'h7, 8'h00);

        // Coarse masking and unmapped addresses
        wr_reg(4'h3, 8'hAB);
        rd_reg("coarse_b_rd", 4'h3, 8'h0B);
        rd_reg("fine_b_rd", 4'h2, 8'h00);
        wr_reg(4'h6, 8'hFF);
        wr_reg(4'hF, 8'hFF);
        rd_reg("addr6_rd", 4'h6, 8'h00);
        rd_reg("addr15_rd", 4'hF, 8'h00);
        rd_reg("mix_after_unmapped", 4'h7, 8'h00);
        wr_reg(4'h3, 8'h00);

        // Period change mid-count: 0x010 then 0x002
        wr_reg(4'h0, 8'h10);
        wait_tog(0, 100, t0);
        repeat (20) @(posedge PHI_S);
        wr_reg(4'h0, 8'h02);
        wait_tog(0, 100, t1);
        check_eq("midcount_int", t1 - t0, 51);
        wait_tog(0, 50, t2);
        check_eq("after_change_int", t2 - t1, 9);

        // Write colliding with reload: old value used once
        wr_reg(4'h0, 8'h04);
        wait_tog(0, 100, t0);
        wait_tog(0, 50, t1);
        check_eq("p4_int", t1 - t0, 15);
        repeat (14) @(posedge PHI_S);
        @(negedge PHI_S);
        WR = 1'b1; ADDR = 4'h0; DIN = 8'h07;
        prev_tone = TONE;
        exp_bit   = ~prev_tone[0];
        @(posedge PHI_S);
        #1;
        tc = cyc;
        check_eq("coll_toggle", TONE[0], exp_bit);
        check_eq("coll_cycle", tc - t1, 15);
        @(negedge PHI_S);
        WR = 1'b0;
        wait_tog(0, 100, t2);
        check_eq("coll_old_int", t2 - tc, 15);
        wait_tog(0, 100, t0);
        check_eq("coll_new_int", t0 - t2, 24);

        // Mid-count reset with max period; write during reset must be dropped
        wr_reg(4'h0, 8'hFF);
        wr_reg(4'h1, 8'h0F);
        rd_reg("coarse_a_rd", 4'h1, 8'h0F);
        wait_tog(0, 200, t0);
        repeat (30) @(posedge PHI_S);
        @(negedge PHI_S);
        RESET = 1'b1;
        WR = 1'b1; ADDR = 4'h7; DIN = 8'hFF;
        @(negedge PHI_S);
        RESET = 1'b0;
        WR = 1'b0;
        check_eq("mid_rst_slot", SLOT, 0);
        check_eq("mid_rst_tone", TONE, 3'b000);
        @(posedge PHI_S);
        #1;
        check_eq("restart_tone1", TONE, 3'b001);
        check_eq("restart_slot1", SLOT, 1);
        @(posedge PHI_S);
        #1;
        check_eq("restart_tone2", TONE, 3'b011);
        check_eq("restart_slot2", SLOT, 2);
        @(posedge PHI_S);
        #1;
        check_eq("restart_tone3", TONE, 3'b111);
        check_eq("restart_slot3", SLOT, 0);
        for (int a = 0; a < 16; a++) rd_reg($sformatf("mid_rst_dout_%0d", a), 4'(a), 8'h00);
        wait_tog(0, 20, t0);
        wait_tog(0, 20, t1);
        check_eq("restart_a_int", t1 - t0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
